// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
// Shared PS/2 receiver types and frame constants.
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

   localparam int   DATA_BITS   = 8;
   localparam int   CNT_W       = $clog2(DATA_BITS);
   localparam logic STOP_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
endpackage

// File: rtl/ps2_scan_fifo.sv
`timescale 1ns/1ps
// Synchronous show-ahead FIFO: rd_data is the head entry read straight from the array.
module ps2_scan_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clock50,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   not_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_pop, do_push;

   assign do_pop    = pop && (count != '0);
   // a same-cycle pop frees the slot, so a push into a full FIFO still lands
   assign do_push   = push && ((count != FULL) || do_pop);
   assign rd_data   = mem[rd_ptr];
   assign not_empty = (count != '0);

   always_ff @(posedge clock50) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push && !do_push;
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver: line conditioning, frame decode with timeout, scan-code FIFO.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int SAMPLE_DIV     = 2,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int CHECK_PARITY   = 1
) (
   input  logic                        clock50,
   input  logic                        reset,
   input  logic                        ps2_clk,
   input  logic                        ps2_data,
   input  logic                        rd_en,
   output logic [7:0]                  scan_code,
   output logic                        scan_valid,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        parity_err,
   output logic                        frame_err,
   output logic                        overflow
);
   localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]            clk_sync, data_sync;
   logic [DW-1:0]         div_cnt;
   logic                  sample;
   logic [FILTER_LEN-1:0] filt;
   logic                  filt_clk, fall, data_s;

   ps2_state_t            state;
   logic [CNT_W-1:0]      bit_cnt;
   logic [DATA_BITS-1:0]  shreg;
   logic                  par_bit, par_ok, push;
   logic [TW-1:0]         to_cnt;

   assign sample = (div_cnt == DW'(SAMPLE_DIV - 1));
   assign data_s = data_sync[1];

   always_ff @(posedge clock50) begin
      if (!reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         div_cnt   <= '0;
         filt      <= '1;
         filt_clk  <= 1'b1;
         fall      <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         div_cnt   <= sample ? '0 : div_cnt + 1'b1;
         if (sample) filt <= {filt[FILTER_LEN-2:0], clk_sync[1]};
         fall <= 1'b0;
         // hysteresis: only a fully agreeing filter moves the filtered clock
         if (&filt) filt_clk <= 1'b1;
         else if (~|filt) begin
            filt_clk <= 1'b0;
            fall     <= filt_clk;
         end
      end
   end

   assign par_ok = ^{shreg, par_bit};
   assign push   = fall && (state == STOP) && (data_s == STOP_LEVEL) &&
                   (par_ok || (CHECK_PARITY == 0));

   always_ff @(posedge clock50) begin
      if (!reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         to_cnt     <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         if (state == IDLE || fall) to_cnt <= '0;
         else                       to_cnt <= to_cnt + 1'b1;

         if (fall) begin
            case (state)
               IDLE: if (data_s == START_LEVEL) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
               DATA: begin
                  shreg[bit_cnt] <= data_s;
                  bit_cnt        <= bit_cnt + 1'b1;
                  if (bit_cnt == CNT_W'(DATA_BITS - 1)) state <= PARITY;
               end
               PARITY: begin
                  par_bit <= data_s;
                  state   <= STOP;
               end
               STOP: begin
                  state      <= IDLE;
                  parity_err <= !par_ok;
                  frame_err  <= (data_s != STOP_LEVEL);
               end
            endcase
         end else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES)) begin
            state     <= IDLE;
            frame_err <= 1'b1;
         end
      end
   end

   ps2_scan_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock50   (clock50),
      .reset     (reset),
      .push      (push),
      .pop       (rd_en),
      .wr_data   (shreg),
      .rd_data   (scan_code),
      .not_empty (scan_valid),
      .count     (fifo_count),
      .overflow  (overflow)
   );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
// Directed and random PS/2 frames against a queue model of the scan-code FIFO.
module tb_ps2_rx_fifo;
   localparam int DEPTH    = 8;
   localparam int HALF     = 40;
   localparam int FALL_MAX = 36;
   localparam int POST     = 40;
   localparam int TMO      = 10000;

   logic       clock50 = 1'b0, reset = 1'b0, reset2 = 1'b0;
   logic       ps2_clk = 1'b1, ps2_data = 1'b1, rd_en = 1'b0, rd_en2 = 1'b0;
   logic [7:0] scan_code, scan_code2;
   logic       scan_valid, scan_valid2, parity_err, parity_err2;
   logic       frame_err, frame_err2, overflow, overflow2;
   logic [3:0] fifo_count, fifo_count2;

   always #10 clock50 = ~clock50;

   ps2_rx_fifo #(.CHECK_PARITY(1)) dut (
      .clock50(clock50), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rd_en(rd_en), .scan_code(scan_code), .scan_valid(scan_valid),
      .fifo_count(fifo_count), .parity_err(parity_err), .frame_err(frame_err),
      .overflow(overflow));

   ps2_rx_fifo #(.CHECK_PARITY(0)) dut_np (
      .clock50(clock50), .reset(reset2), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rd_en(rd_en2), .scan_code(scan_code2), .scan_valid(scan_valid2),
      .fifo_count(fifo_count2), .parity_err(parity_err2), .frame_err(frame_err2),
      .overflow(overflow2));

   int checks = 0, errors = 0;
   int cyc = 0, pe_n = 0, fe_n = 0, ov_n = 0, pe2_n = 0, fe_cyc = 0, last_low = 0;
   logic       sv_fall, sv_next;
   logic [3:0] cnt_next;
   logic [7:0] q[$];

   always @(negedge clock50) begin
      cyc++;
      if (parity_err)  pe_n++;
      if (frame_err) begin fe_n++; fe_cyc = cyc; end
      if (overflow)    ov_n++;
      if (parity_err2) pe2_n++;
   end

   initial begin
      #4ms;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock50);
      #1;
   endtask

   task automatic check_fifo();
      chk("fifo_count", fifo_count, q.size());
      chk("scan_valid", scan_valid, q.size() != 0);
      if (q.size() != 0) chk("scan_code", scan_code, q[0]);
   endtask

   task automatic read_one();
      if (q.size() != 0) chk("rd_head", scan_code, q[0]);
      rd_en = 1'b1;
      wait_cyc(1);
      rd_en = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
      check_fifo();
   endtask

   // one PS/2 bit: data set while clock high, then a falling edge
   task automatic ps2_bit(input logic b, input bit watch, input bit rd_fall);
      int n;
      ps2_data = b;
      wait_cyc(HALF);
      ps2_clk  = 1'b0;
      last_low = cyc;
      if (watch) begin
         n = 0;
         while (dut.fall !== 1'b1 && n < FALL_MAX) begin wait_cyc(1); n++; end
         chk("stop_fall", dut.fall, 1'b1);
         sv_fall = scan_valid;
         if (rd_fall) rd_en = 1'b1;
         wait_cyc(1);
         rd_en    = 1'b0;
         sv_next  = scan_valid;
         cnt_next = fifo_count;
         wait_cyc(HALF - n);
      end else wait_cyc(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                             input bit rd_fall);
      int   pe0, fe0, ov0;
      logic p;
      bit   exp_ov;
      pe0 = pe_n; fe0 = fe_n; ov0 = ov_n;
      p   = ~(^d) ^ bad_par;
      ps2_bit(1'b0, 0, 0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i], 0, 0);
      ps2_bit(p, 0, 0);
      ps2_bit(stop, 1, rd_fall);
      wait_cyc(POST);
      if (rd_fall && q.size() != 0) void'(q.pop_front());
      exp_ov = 1'b0;
      if (stop && !bad_par) begin
         if (q.size() < DEPTH) q.push_back(d);
         else exp_ov = 1'b1;
      end
      chk("parity_err", pe_n - pe0, bad_par);
      chk("frame_err", fe_n - fe0, !stop);
      chk("overflow", ov_n - ov0, exp_ov);
      check_fifo();
   endtask

   initial begin
      int fe0, pe0, pe2_0, dly, nr, k;
      logic [7:0] d;

      wait_cyc(3);
      chk("rst_valid", scan_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_code", scan_code, 0);
      chk("rst_errs", {parity_err, frame_err, overflow}, 0);
      reset = 1'b1;
      wait_cyc(20);

      send_frame(8'h1C, 0, 1, 0);
      chk("lat_at_fall", sv_fall, 0);
      chk("lat_valid", sv_next, 1);
      chk("lat_count", cnt_next, 1);
      read_one();

      reset2 = 1'b1;
      wait_cyc(5);
      pe2_0 = pe2_n;
      send_frame(8'h1C, 1, 1, 0);
      chk("np_parity_err", pe2_n - pe2_0, 1);
      chk("np_count", fifo_count2, 1);
      chk("np_valid", scan_valid2, 1);
      chk("np_code", scan_code2, 8'h1C);
      reset2 = 1'b0;

      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h29, 0, 1, 0);
      read_one();

      // stall after four data bits of 0x5A
      fe0 = fe_n; pe0 = pe_n;
      ps2_bit(1'b0, 0, 0);
      for (int i = 0; i < 4; i++) ps2_bit(d[i] ^ d[i] ^ (8'h5A >> i) & 1'b1, 0, 0);
      wait_cyc(12500);
      dly = fe_cyc - last_low;
      chk("timeout_pulses", fe_n - fe0, 1);
      chk("timeout_window", (dly >= TMO + 10) && (dly <= TMO + 40), 1);
      chk("timeout_no_perr", pe_n - pe0, 0);
      check_fifo();
      send_frame(8'h5A, 0, 1, 0);
      read_one();

      for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1, 0);
      chk("full_count", fifo_count, DEPTH);
      for (int i = 0; i < 8; i++) read_one();
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 1, 0);
      send_frame(8'h09, 0, 1, 1);
      chk("full_rd_count", fifo_count, DEPTH);
      for (int i = 0; i < 8; i++) read_one();

      send_frame(8'h33, 0, 1, 0);
      fe0 = fe_n; pe0 = pe_n;
      for (int i = 0; i < 8; i++) begin
         #($urandom_range(0, 19));
         ps2_clk = 1'b0; #3; ps2_clk = 1'b1;
         wait_cyc(7);
      end
      for (int i = 0; i < 4; i++) begin
         ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(25);
      end
      chk("glitch_errs", (fe_n - fe0) + (pe_n - pe0), 0);
      check_fifo();
      ps2_bit(1'b0, 0, 0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b1, 0, 0);
      reset = 1'b0;
      wait_cyc(1);
      reset = 1'b1;
      q.delete();
      wait_cyc(2);
      chk("mrst_valid", scan_valid, 0);
      chk("mrst_count", fifo_count, 0);
      chk("mrst_code", scan_code, 0);
      chk("mrst_errs", {parity_err, frame_err, overflow}, 0);
      wait_cyc(200);
      chk("mrst_no_err", (fe_n - fe0) + (pe_n - pe0), 0);
      send_frame(8'hA5, 0, 1, 0);
      read_one();

      for (int i = 0; i < 15; i++) begin
         d = 8'($urandom);
         k = $urandom_range(0, 5);
         send_frame(d, k == 0, k != 1, 0);
         nr = $urandom_range(0, 2);
         for (int j = 0; j < nr; j++) read_one();
      end
      for (int i = 0; i < DEPTH && q.size() != 0; i++) read_one();
      chk("drained", fifo_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
